// File: rtl/key_pkg.sv
// key_pkg: state encodings and helpers shared by the key-handling stages.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } key_state_t;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst)
        if (!rst) {q, meta} <= {RST_VAL, RST_VAL};
        else      {q, meta} <= {meta, d};

endmodule

// File: rtl/key_debounce.sv
// key_debounce: synchronizes a bouncing key and accepts a level only after it
// holds for DEBOUNCE_CYCLES consecutive cycles.
module key_debounce
    import key_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1000000,
    parameter logic KEY_ACTIVE      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic busy
);

    localparam int            CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    key_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          key_s, pressed_s;

    // Reset to the released level so leaving reset never looks like a press.
    sync_2ff #(.RST_VAL(~KEY_ACTIVE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_in),
        .q   (key_s)
    );

    assign pressed_s = key_s == KEY_ACTIVE;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end

    // cnt only advances while a filter interval continues; every transition clears it.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        case (state)
            IDLE:       state_n = pressed_s ? PRESS_FILT : IDLE;
            PRESS_FILT: if (!pressed_s)       state_n = IDLE;
                        else if (cnt == LAST) state_n = DOWN;
                        else                  cnt_n   = cnt + 1'b1;
            DOWN:       state_n = pressed_s ? DOWN : REL_FILT;
            REL_FILT:   if (pressed_s)        state_n = DOWN;
                        else if (cnt == LAST) state_n = IDLE;
                        else                  cnt_n   = cnt + 1'b1;
            default:    state_n = IDLE;
        endcase
    end

    assign key_level = state == DOWN || state == REL_FILT;
    assign busy      = state == PRESS_FILT || state == REL_FILT;

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench; stimulus queues expected output changes by edge number.
module tb_key_debounce;
    import key_pkg::*;

    typedef struct {
        int         id;
        int         at_edge;
        logic [1:0] val;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, key_a = 1'b1, key_b = 1'b1;
    logic lvl_a, busy_a, lvl_b, busy_b;
    logic [1:0] prev_a = 2'b00, prev_b = 2'b00;
    int cyc = 0, checks = 0, failures = 0;
    exp_t q[$];

    key_debounce #(.DEBOUNCE_CYCLES(16), .KEY_ACTIVE(1'b0)) dut_a (
        .clk(clk), .rst(rst), .key_in(key_a), .key_level(lvl_a), .busy(busy_a)
    );

    key_debounce #(.DEBOUNCE_CYCLES(1), .KEY_ACTIVE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .key_in(key_b), .key_level(lvl_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input int id, input int at, input logic [1:0] v);
        exp_t e;
        e.id = id;
        e.at_edge = at;
        e.val = v;
        q.push_back(e);
    endtask

    task automatic on_change(input int id, input logic [1:0] v);
        exp_t e;
        checks++;
        if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change: dut %0d {level,busy}=%b at edge %0d, expected no change", id, v, cyc);
        end else begin
            e = q.pop_front();
            if (e.id != id || e.at_edge != cyc || e.val != v) begin
                failures++;
                $display("FAIL event: got dut %0d {level,busy}=%b at edge %0d expected dut %0d =%b at edge %0d",
                         id, v, cyc, e.id, e.val, e.at_edge);
            end
        end
    endtask

    // Monitor: any change of {key_level,busy} is matched against the queue head.
    initial forever begin
        @(posedge clk);
        #1;
        if ({lvl_a, busy_a} != prev_a) on_change(0, {lvl_a, busy_a});
        if ({lvl_b, busy_b} != prev_b) on_change(1, {lvl_b, busy_b});
        prev_a = {lvl_a, busy_a};
        prev_b = {lvl_b, busy_b};
    end

    initial begin
        int n, r;
        #2 rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("reset_hold_a", {lvl_a, busy_a}, 0);
            chk("reset_hold_b", {lvl_b, busy_b}, 0);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);

        n = cyc; key_a = 1'b0;
        expect_evt(0, n + 3, 2'b01);
        expect_evt(0, n + 19, 2'b10);
        repeat (40) @(negedge clk);

        n = cyc;
        for (int j = 0; j < 5; j++) begin
            key_a = 1'b1;
            expect_evt(0, n + 6 * j + 3, 2'b11);
            expect_evt(0, n + 6 * j + 6, 2'b10);
            repeat (3) @(negedge clk);
            key_a = 1'b0;
            repeat (3) @(negedge clk);
        end
        key_a = 1'b1;
        expect_evt(0, n + 33, 2'b11);
        expect_evt(0, n + 49, 2'b00);
        repeat (60) @(negedge clk);

        n = cyc; key_a = 1'b0;
        expect_evt(0, n + 3, 2'b01);
        repeat (10) @(negedge clk);
        key_a = 1'b1;
        expect_evt(0, n + 13, 2'b00);
        repeat (30) @(negedge clk);
        chk("glitch_state", dut_a.state, IDLE);
        chk("glitch_out", {lvl_a, busy_a}, 0);

        n = cyc; key_a = 1'b0;
        expect_evt(0, n + 3, 2'b01);
        repeat (11) @(negedge clk);
        chk("mid_filter_cnt", dut_a.cnt, 8);
        rst = 1'b0;
        expect_evt(0, cyc + 1, 2'b00);
        #1 chk("rst_mid_filter", {lvl_a, busy_a}, 0);
        repeat (5) @(negedge clk);
        rst = 1'b1; r = cyc;
        expect_evt(0, r + 3, 2'b01);
        expect_evt(0, r + 19, 2'b10);
        repeat (30) @(negedge clk);

        rst = 1'b0;
        expect_evt(0, cyc + 1, 2'b00);
        #1 chk("rst_in_down", {lvl_a, busy_a}, 0);
        key_a = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);

        n = cyc; key_b = 1'b0;
        expect_evt(1, n + 3, 2'b01);
        expect_evt(1, n + 4, 2'b10);
        repeat (10) @(negedge clk);
        n = cyc; key_b = 1'b1;
        expect_evt(1, n + 3, 2'b11);
        expect_evt(1, n + 4, 2'b00);
        repeat (10) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: %0d expected events never seen, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive clk cycles an input level must hold to be accepted (legal range >= 1).
REQ-002 The block SHALL have parameter KEY_ACTIVE, default 1'b0, meaning the raw key_in level that represents "pressed".
REQ-003 The block SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port key_in, input, 1, raw mechanical key, asynchronous to clk, bouncing.
REQ-006 The block SHALL have port key_level, output, 1, debounced key state, 1 = pressed, independent of KEY_ACTIVE.
REQ-007 The block SHALL have port busy, output, 1, high while a filter interval is running.

Function
REQ-008 The block SHALL pass key_in through a 2-flop synchronizer; pressed_s = (sync output == KEY_ACTIVE).
REQ-009 The block SHALL implement an FSM with states IDLE, PRESS_FILT, DOWN, REL_FILT and a counter cnt of width clog2(DEBOUNCE_CYCLES), minimum 1 bit.
REQ-010 IDLE: if pressed_s, the FSM SHALL go to PRESS_FILT with cnt=0; otherwise it SHALL stay.
REQ-011 PRESS_FILT: if !pressed_s, the FSM SHALL return to IDLE with cnt=0 (glitch rejected); else if cnt==DEBOUNCE_CYCLES-1, go to DOWN with cnt=0; else cnt SHALL increment.
REQ-012 DOWN: if !pressed_s, the FSM SHALL go to REL_FILT with cnt=0; otherwise it SHALL stay.
REQ-013 REL_FILT: if pressed_s, the FSM SHALL return to DOWN with cnt=0; else if cnt==DEBOUNCE_CYCLES-1, go to IDLE with cnt=0; else cnt SHALL increment.
REQ-014 key_level SHALL be 1 exactly when state is DOWN or REL_FILT; it SHALL be decoded from registered state only, with no combinational path from key_in.
REQ-015 busy SHALL be 1 exactly when state is PRESS_FILT or REL_FILT.
REQ-016 Latency: for a clean level change held stable, key_level SHALL change after the (DEBOUNCE_CYCLES+3)th rising edge, counting the first edge that samples the new key_in level.
REQ-017 Any opposite-level sample during a filter interval SHALL abort that interval, leaving key_level unchanged; the next interval SHALL restart from cnt=0.
REQ-018 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 With DEBOUNCE_CYCLES=1, a filter state SHALL last exactly one cycle (latency 4 edges).
REQ-020 key_level and busy SHALL never be high in the same cycle as an illegal or unreachable state; unreachable encodings SHALL recover to IDLE on the next edge.

Reset
REQ-021 While rst is low, the state SHALL be IDLE, cnt=0, and both synchronizer flops SHALL equal ~KEY_ACTIVE (released), so no false press is generated after reset.
REQ-022 Outputs SHALL reset to key_level=0 and busy=0 immediately on rst assertion, including mid-filter or while in DOWN.
REQ-023 After rst deassertion, a key still held pressed SHALL require the full REQ-016 latency before key_level rises.

Structure
REQ-024 The FSM state encodings (IDLE=0, PRESS_FILT=1, DOWN=2, REL_FILT=3, 2 bits) SHALL live in the shared package key_pkg, for reuse by the downstream edge-pulse and key-handling stages.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module sync_2ff, with its reset value given as a parameter.
REQ-026 key_level SHALL be the intended input for the downstream single-pulse edge detector; this block itself SHALL generate no edge pulses.

Verification (DEBOUNCE_CYCLES=16, KEY_ACTIVE=0)
REQ-027 Reset with key_in=1 held for 100 cycles -> key_level=0 and busy=0 throughout.
REQ-028 Clean press: key_in 1->0 held 40 cycles -> busy rises after edge 3, key_level rises after edge 19 exactly, busy falls with it.
REQ-029 Glitch: key_in=0 for 10 cycles then 1 -> key_level never asserts; busy returns to 0 and the FSM is back in IDLE.
REQ-030 Bouncy release: from DOWN, key_in toggles every 3 cycles for 30 cycles then holds 1 -> key_level stays 1 during the bounce and falls 19 edges after the final transition.
REQ-031 Reset mid-filter: rst low while in PRESS_FILT with cnt=8, key_in held 0 -> outputs 0 at once; after release, key_level rises 19 edges later.
REQ-032 With DEBOUNCE_CYCLES=1, a clean press -> key_level rises after edge 4.
